// File: rtl/grid_walk_pkg.sv
// Shared encodings for the grid walker: rotation direction, axis select and edge mode.
package grid_walk_pkg;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  localparam logic AXIS_X = 1'b0;
  localparam logic AXIS_Y = 1'b1;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

endpackage

// File: rtl/rotor_decode.sv
// Quadrature rotary encoder decoder: 2-flop synchronisers, q1/q2 filter FSM and a registered
// one-cycle detent event with its direction.
module rotor_decode
  import grid_walk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ROT_A,
  input  logic ROT_B,
  output logic rot_evt,
  output logic rot_dir
);

  logic [1:0] a_sync;
  logic [1:0] b_sync;
  logic       a_s;
  logic       b_s;
  logic       q1;
  logic       q2;
  logic       q1_d;
  logic       q2_d;
  logic       q1_next;
  logic       q2_next;

  assign a_s = a_sync[1];
  assign b_s = b_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sync  <= '0;
      b_sync  <= '0;
      q1      <= 1'b0;
      q2      <= 1'b0;
      q1_d    <= 1'b0;
      q2_d    <= 1'b0;
      rot_evt <= 1'b0;
      rot_dir <= DIR_DEC;
    end else begin
      a_sync  <= {a_sync[0], ROT_A};
      b_sync  <= {b_sync[0], ROT_B};
      q1      <= q1_next;
      q2      <= q2_next;
      q1_d    <= q1;
      q2_d    <= q2;
      rot_evt <= q1 & ~q1_d;
      rot_dir <= q2_d ? DIR_INC : DIR_DEC;
    end
  end

  // q1 only re-arms after both phases return low, so bounce on one phase cannot re-fire.
  always_comb begin
    q1_next = q1;
    q2_next = q2;
    if (a_s && b_s)        q1_next = 1'b1;
    else if (!a_s && !b_s) q1_next = 1'b0;
    if (a_s && !b_s)       q2_next = 1'b1;
    else if (!a_s && b_s)  q2_next = 1'b0;
  end

endmodule

// File: rtl/grid_walk_param.sv
// Cursor on an (X_MAX+1) x (Y_MAX+1) grid driven by a rotary encoder, with load,
// hold, variable step, axis select and saturate/wrap edge behaviour.
module grid_walk_param #(
  parameter int XW    = 4,
  parameter int YW    = 4,
  parameter int X_MAX = 15,
  parameter int Y_MAX = 15,
  parameter int SW    = 2,
  parameter int WRAP  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ROT_A,
  input  logic               ROT_B,
  input  logic               axis_sel,
  input  logic [SW-1:0]      step,
  input  logic               hold,
  input  logic               load,
  input  logic [XW-1:0]      load_x,
  input  logic [YW-1:0]      load_y,
  output logic [XW-1:0]      x_pos,
  output logic [YW-1:0]      y_pos,
  output logic [XW+YW-1:0]   led,
  output logic               at_edge,
  output logic               move
);
  import grid_walk_pkg::*;

  localparam logic [XW:0]   XM   = (XW+1)'(X_MAX);
  localparam logic [XW:0]   XM1  = (XW+1)'(X_MAX + 1);
  localparam logic [XW-1:0] XMN  = XW'(X_MAX);
  localparam logic [YW:0]   YM   = (YW+1)'(Y_MAX);
  localparam logic [YW:0]   YM1  = (YW+1)'(Y_MAX + 1);
  localparam logic [YW-1:0] YMN  = YW'(Y_MAX);

  logic          rot_evt;
  logic          rot_dir;
  logic          advance;
  logic [XW:0]   xc, sx, x_sum, x_diff, x_rdn, x_up, x_dn, x_res;
  logic [YW:0]   yc, sy, y_sum, y_diff, y_rdn, y_up, y_dn, y_res;
  logic [XW-1:0] x_next, x_load;
  logic [YW-1:0] y_next, y_load;

  rotor_decode u_decode (
    .clk     (clk),
    .reset   (reset),
    .ROT_A   (ROT_A),
    .ROT_B   (ROT_B),
    .rot_evt (rot_evt),
    .rot_dir (rot_dir)
  );

  assign advance = rot_evt && !hold && (step != '0);

  // All arithmetic is one bit wider than the axis so c+s and c+(M+1)-s never overflow.
  always_comb begin
    xc     = {1'b0, x_pos};
    sx     = (XW+1)'(step);
    x_sum  = xc + sx;
    x_diff = xc - sx;
    x_rdn  = xc + XM1 - sx;
    yc     = {1'b0, y_pos};
    sy     = (YW+1)'(step);
    y_sum  = yc + sy;
    y_diff = yc - sy;
    y_rdn  = yc + YM1 - sy;
    x_up   = (x_sum > XM) ? XM : x_sum;
    x_dn   = (sx > xc) ? '0 : x_diff;
    y_up   = (y_sum > YM) ? YM : y_sum;
    y_dn   = (sy > yc) ? '0 : y_diff;
    case (WRAP)
      MODE_SAT: ;
      MODE_WRAP: begin
        x_up = (x_sum > XM) ? x_sum - XM1 : x_sum;
        x_dn = (x_rdn > XM) ? x_rdn - XM1 : x_rdn;
        y_up = (y_sum > YM) ? y_sum - YM1 : y_sum;
        y_dn = (y_rdn > YM) ? y_rdn - YM1 : y_rdn;
      end
      default: ;
    endcase
    x_res = (rot_dir == DIR_INC) ? x_up : x_dn;
    y_res = (rot_dir == DIR_INC) ? y_up : y_dn;
    // Oversized steps are a usage error; keep the cursor on the grid regardless.
    if (x_res > XM) x_res = XM;
    if (y_res > YM) y_res = YM;
    x_next = x_res[XW-1:0];
    y_next = y_res[YW-1:0];
    x_load = ({1'b0, load_x} > XM) ? XMN : load_x;
    y_load = ({1'b0, load_y} > YM) ? YMN : load_y;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_pos <= '0;
      y_pos <= '0;
      move  <= 1'b0;
    end else begin
      move <= 1'b0;
      if (load) begin
        x_pos <= x_load;
        y_pos <= y_load;
      end else if (advance) begin
        if (axis_sel == AXIS_X) begin
          x_pos <= x_next;
          move  <= (x_next != x_pos);
        end else begin
          y_pos <= y_next;
          move  <= (y_next != y_pos);
        end
      end
    end
  end

  assign led     = {x_pos, y_pos};
  assign at_edge = (axis_sel == AXIS_Y) ? ((y_pos == '0) || (y_pos == YMN))
                                        : ((x_pos == '0) || (x_pos == XMN));

endmodule
